// File: rtl/spi_frame_serializer_if.sv
// Request channel between the upstream queue and the SPI frame serializer.
// The upstream side uses the master modport and the serializer uses the slave modport.
interface spi_frame_serializer_if #(
    parameter int ADDRW   = 8,
    parameter int OPCODEW = 2,
    parameter int DATAW   = 8
);
    logic               valid_in;
    logic [OPCODEW-1:0] opcode;
    logic [ADDRW-1:0]   addr;
    logic [DATAW-1:0]   data;
    logic               with_data;
    logic               ready_out;

    modport master (output valid_in, opcode, addr, data, with_data, input ready_out);
    modport slave  (input valid_in, opcode, addr, data, with_data, output ready_out);
endinterface

// File: rtl/spi_frame_serializer.sv
// Queues opcode/address(/payload) requests in a FIFO and shifts each one out as a cs_n-framed
// SPI frame. spi_clk is oversampled on the fast clk and is not used as a clock.
module spi_frame_serializer #(
    parameter int ADDRW   = 8,
    parameter int OPCODEW = 2,
    parameter int DATAW   = 8,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_clk,
    input  logic                         lsb_first,
    input  logic                         shift_pol,
    spi_frame_serializer_if.slave        req,
    output logic                         miso,
    output logic                         cs_n,
    output logic                         busy,
    output logic                         frame_done,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);
    localparam int FRAMEW = OPCODEW + ADDRW + DATAW;
    localparam int SHORTW = OPCODEW + ADDRW;
    localparam int ENTW   = FRAMEW + 1;
    localparam int PTRW   = $clog2(DEPTH);
    localparam int LVLW   = $clog2(DEPTH + 1);
    localparam int CNTW   = $clog2(FRAMEW);
    localparam logic [CNTW-1:0] LAST_SHORT = CNTW'(SHORTW - 1);
    localparam logic [CNTW-1:0] LAST_FULL  = CNTW'(FRAMEW - 1);
    localparam logic [LVLW-1:0] FULL_LVL   = LVLW'(DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;
    state_t state, state_nxt;

    logic              s1, s2, s3;
    logic              rise, fall, shift_edge;
    logic [ENTW-1:0]   mem [DEPTH];
    logic [PTRW-1:0]   wr_ptr, rd_ptr;
    logic              push, pop, shift_go, tail_go;
    logic              head_wd;
    logic [FRAMEW-1:0] head_frame, load_val;
    logic [FRAMEW-1:0] shreg;
    logic [CNTW-1:0]   cnt;
    logic              lsb_q, pol_q;

    // NOTE: every flop is updated with <= so all of them sample values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= spi_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise       = s2 & ~s3;
    assign fall       = ~s2 & s3;
    assign shift_edge = pol_q ? rise : fall;

    // When a pop is happening, the slot it frees can be refilled in the same cycle.
    assign req.ready_out = (fifo_level != FULL_LVL) || pop;
    assign push          = req.valid_in && req.ready_out;

    // NOTE: the storage array has no reset. Which entries are valid is tracked only by the pointers and fifo_level.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {req.with_data, req.opcode, req.addr, req.data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVLW'(1);
                2'b01:   fifo_level <= fifo_level - LVLW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // A short frame is aligned so that its first bit sits where the chosen shift direction reads it.
    assign {head_wd, head_frame} = mem[rd_ptr];
    always_comb begin
        load_val = head_frame;
        if (!head_wd)
            load_val = lsb_first ? FRAMEW'(head_frame[FRAMEW-1:DATAW])
                                 : {head_frame[FRAMEW-1:DATAW], {DATAW{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal driven in always_comb gets a default first, so no latches are inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fifo_level != '0)            state_nxt = SHIFT;
            SHIFT:   if (shift_edge && cnt == '0)     state_nxt = TAIL;
            TAIL:    if (shift_edge)                  state_nxt = IDLE;
            default:                                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        shift_go = 1'b0;
        tail_go  = 1'b0;
        busy     = (state != IDLE);
        cs_n     = (state == IDLE);
        case (state)
            IDLE:    pop      = (fifo_level != '0);
            SHIFT:   shift_go = shift_edge;
            TAIL:    tail_go  = shift_edge;
            default: ;
        endcase
    end

    // Bit order and edge polarity are captured at load, so later config changes only affect the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            cnt        <= '0;
            lsb_q      <= 1'b0;
            pol_q      <= 1'b0;
            miso       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= tail_go;
            if (pop) begin
                shreg <= load_val;
                cnt   <= head_wd ? LAST_FULL : LAST_SHORT;
                lsb_q <= lsb_first;
                pol_q <= shift_pol;
            end else if (shift_go) begin
                miso  <= lsb_q ? shreg[0] : shreg[FRAMEW-1];
                shreg <= lsb_q ? (shreg >> 1) : (shreg << 1);
                cnt   <= cnt - CNTW'(1);
            end else if (tail_go) begin
                miso  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_frame_serializer.sv
// Directed bench for spi_frame_serializer. Frames are read one bit per active spi_clk edge
// and compared with hand-computed bit sequences.
module tb_spi_frame_serializer;
    localparam int ADDRW = 8, OPCODEW = 2, DATAW = 8, DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       spi_clk = 1'b1;
    logic       lsb_first = 1'b0;
    logic       shift_pol = 1'b0;
    logic       miso, cs_n, busy, frame_done;
    logic [2:0] fifo_level;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    spi_frame_serializer_if #(.ADDRW(ADDRW), .OPCODEW(OPCODEW), .DATAW(DATAW)) req ();

    spi_frame_serializer #(.ADDRW(ADDRW), .OPCODEW(OPCODEW), .DATAW(DATAW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_clk    (spi_clk),
        .lsb_first  (lsb_first),
        .shift_pol  (shift_pol),
        .req        (req.slave),
        .miso       (miso),
        .cs_n       (cs_n),
        .busy       (busy),
        .frame_done (frame_done),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Changes spi_clk, then waits long enough for the synchroniser to react.
    task automatic spi_edge(input logic lvl);
        spi_clk = lvl;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d, input logic wd);
        req.valid_in  = 1'b1;
        req.opcode    = op;
        req.addr      = a;
        req.data      = d;
        req.with_data = wd;
        @(negedge clk);
        req.valid_in  = 1'b0;
    endtask

    // Reads nbits bits. The first bit received ends up as the most significant bit of rx.
    task automatic read_frame(input int nbits, input logic act, output logic [31:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_edge(~act);
            spi_edge(act);
            rx = {rx[30:0], miso};
            check("frame_cs_low", cs_n, 1'b0);
        end
    endtask

    task automatic tail(input logic act);
        spi_edge(~act);
        spi_edge(act);
    endtask

    initial begin
        logic [31:0] rx, rx2;
        logic [9:0]  exp_f [6];
        int          d0;
        logic        seen_hi;

        req.valid_in = 1'b0; req.opcode = '0; req.addr = '0; req.data = '0; req.with_data = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_miso", miso, 1'b0);
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_ready", req.ready_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic frame: {10, A5}, sent MSB first on falling edges
        push(2'b10, 8'hA5, 8'h00, 1'b0);
        check("basic_level_after_push", fifo_level, 3'd1);
        check("basic_cs_still_high", cs_n, 1'b1);
        @(negedge clk);
        check("basic_cs_low", cs_n, 1'b0);
        check("basic_busy", busy, 1'b1);
        check("basic_level_popped", fifo_level, 3'd0);
        d0 = done_cnt;
        read_frame(10, 1'b0, rx);
        check("basic_bits", rx, 32'h2A5);
        check("basic_busy_in_tail", busy, 1'b1);
        check("basic_no_early_done", done_cnt, d0);
        tail(1'b0);
        check("basic_cs_high_end", cs_n, 1'b1);
        check("basic_busy_end", busy, 1'b0);
        check("basic_miso_end", miso, 1'b0);
        check("basic_done_pulse", done_cnt, d0 + 1);

        // Payload, LSB first, shifting on rising edges: {01, 3C, 81}
        shift_pol = 1'b1; lsb_first = 1'b1;
        push(2'b01, 8'h3C, 8'h81, 1'b1);
        @(negedge clk);
        d0 = done_cnt;
        read_frame(18, 1'b1, rx);
        check("payload_bits", rx, 32'h204F2);
        check("payload_no_early_done", done_cnt, d0);
        tail(1'b1);
        check("payload_cs_high", cs_n, 1'b1);
        check("payload_done_pulse", done_cnt, d0 + 1);

        // Fill with spi_clk static. Entry 1 is popped, entries 2..5 queue, and entry 6 is ignored.
        shift_pol = 1'b0; lsb_first = 1'b0;
        for (int k = 1; k <= 6; k++) push(2'(k), 8'(8'h10 + k), 8'h00, 1'b0);
        check("fill_level", fifo_level, 3'd4);
        check("fill_ready_low", req.ready_out, 1'b0);
        check("fill_busy", busy, 1'b1);
        exp_f[0] = 10'h111; exp_f[1] = 10'h212; exp_f[2] = 10'h313;
        exp_f[3] = 10'h014; exp_f[4] = 10'h115; exp_f[5] = 10'h3E7;
        d0 = done_cnt;
        for (int f = 0; f < 6; f++) begin
            read_frame(10, 1'b0, rx);
            check($sformatf("fill_frame%0d", f), rx, 32'(exp_f[f]));
            if (f == 0) begin
                // Hold a request while full. It can only be accepted in the cycle that pops entry 2.
                req.valid_in = 1'b1; req.opcode = 2'b11; req.addr = 8'hE7; req.with_data = 1'b0;
                tail(1'b0);
                repeat (2) @(negedge clk);
                req.valid_in = 1'b0;
                check("full_simul_level", fifo_level, 3'd4);
                check("full_simul_ready", req.ready_out, 1'b0);
            end else begin
                tail(1'b0);
            end
        end
        check("fill_done_count", done_cnt, d0 + 6);
        check("fill_level_empty", fifo_level, 3'd0);
        check("fill_idle", busy, 1'b0);

        // Config change mid-frame: the current frame stays MSB first, and the next frame is LSB first.
        push(2'b11, 8'h0F, 8'h00, 1'b0);
        push(2'b01, 8'h80, 8'h00, 1'b0);
        @(negedge clk);
        read_frame(3, 1'b0, rx);
        lsb_first = 1'b1;
        read_frame(7, 1'b0, rx2);
        check("cfg_frame_a", {rx[2:0], rx2[6:0]}, 32'h30F);
        tail(1'b0);
        read_frame(10, 1'b0, rx);
        check("cfg_frame_b", rx, 32'h006);
        tail(1'b0);
        lsb_first = 1'b0;

        // Reset applied mid-frame while miso is high and one entry is queued
        push(2'b11, 8'hFF, 8'h00, 1'b0);
        push(2'b11, 8'hFF, 8'h00, 1'b0);
        read_frame(2, 1'b0, rx);
        check("pre_rst_miso", miso, 1'b1);
        check("pre_rst_level", fifo_level, 3'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_miso", miso, 1'b0);
        check("mid_rst_cs_n", cs_n, 1'b1);
        check("mid_rst_ready", req.ready_out, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_level", fifo_level, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        seen_hi = 1'b0;
        for (int i = 0; i < 12; i++) begin
            spi_edge(1'b1);
            if (miso !== 1'b0 || cs_n !== 1'b1) seen_hi = 1'b1;
            spi_edge(1'b0);
            if (miso !== 1'b0 || cs_n !== 1'b1) seen_hi = 1'b1;
        end
        check("post_rst_quiet", seen_hi, 1'b0);
        check("post_rst_no_done", done_cnt, d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
